// File: rtl/vtg_pkg.sv
// Shared types and limits for the video timing generator (vid_timing_gen) and its
// per-window decoder.
package vtg_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DLY_MAX   = 4;
  localparam int N_WIN_MAX = 4;

  typedef enum logic {
    VTG_IDLE = 1'b0,
    VTG_RUN  = 1'b1
  } vtg_state_e;

endpackage

// File: rtl/vtg_win_dec.sv
// One frame-buffer read window. Compares the active-area coordinate against the
// window origin and size. Sums are one bit wider so the range check cannot wrap.
module vtg_win_dec
  import vtg_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             de,
  input  logic [CNT_W-1:0] rel_x,
  input  logic [CNT_W-1:0] rel_y,
  input  logic [CNT_W-1:0] hoff,
  input  logic [CNT_W-1:0] voff,
  input  logic [CNT_W-1:0] hres,
  input  logic [CNT_W-1:0] vres,
  output logic             rden
);

  logic [CNT_W:0] x_end;
  logic [CNT_W:0] y_end;
  logic           in_x;
  logic           in_y;

  assign x_end = {1'b0, hoff} + {1'b0, hres};
  assign y_end = {1'b0, voff} + {1'b0, vres};

  // A zero size makes the lower bound meet the upper bound, so it never matches.
  assign in_x = (rel_x >= hoff) && ({1'b0, rel_x} < x_end);
  assign in_y = (rel_y >= voff) && ({1'b0, rel_y} < y_end);

  // Gating with DE clips the window to the active area.
  assign rden = de && in_x && in_y;

endmodule

// File: rtl/vid_timing_gen.sv
// Video timing generator: HS/VS/DE, per-window read enables, and frame-start, all
// decoded from frame-shadowed timing and delayed DLY cycles. Coordinates via VTG_COORD_EN.
module vid_timing_gen
  import vtg_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int N_WIN  = 2,
  parameter int DLY    = 2,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic                   I_pxl_clk,
  input  logic                   I_rst_n,
  input  logic                   I_en,
  input  logic                   I_cfg_upd,
  input  logic [CNT_W-1:0]       I_h_total,
  input  logic [CNT_W-1:0]       I_h_sync,
  input  logic [CNT_W-1:0]       I_h_bporch,
  input  logic [CNT_W-1:0]       I_h_res,
  input  logic [CNT_W-1:0]       I_v_total,
  input  logic [CNT_W-1:0]       I_v_sync,
  input  logic [CNT_W-1:0]       I_v_bporch,
  input  logic [CNT_W-1:0]       I_v_res,
  input  logic [N_WIN*CNT_W-1:0] I_win_hoff,
  input  logic [N_WIN*CNT_W-1:0] I_win_voff,
  input  logic [N_WIN*CNT_W-1:0] I_win_hres,
  input  logic [N_WIN*CNT_W-1:0] I_win_vres,
  output logic                   O_de,
  output logic                   O_hs,
  output logic                   O_vs,
  output logic [N_WIN-1:0]       O_rden,
  output logic                   O_fs,
  output logic                   O_upd_ack,
  output logic                   O_busy
`ifdef VTG_COORD_EN
  ,
  output logic [CNT_W-1:0]       O_x,
  output logic [CNT_W-1:0]       O_y
`endif
);

  if (N_WIN < 1 || N_WIN > N_WIN_MAX) begin : g_bad_n_win
    $error("vid_timing_gen: N_WIN out of range");
  end
  if (DLY < 1 || DLY > DLY_MAX) begin : g_bad_dly
    $error("vid_timing_gen: DLY out of range");
  end

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  typedef struct packed {
    logic [CNT_W-1:0]       h_total;
    logic [CNT_W-1:0]       h_sync;
    logic [CNT_W-1:0]       h_bporch;
    logic [CNT_W-1:0]       h_res;
    logic [CNT_W-1:0]       v_total;
    logic [CNT_W-1:0]       v_sync;
    logic [CNT_W-1:0]       v_bporch;
    logic [CNT_W-1:0]       v_res;
    logic [N_WIN*CNT_W-1:0] hoff;
    logic [N_WIN*CNT_W-1:0] voff;
    logic [N_WIN*CNT_W-1:0] hres;
    logic [N_WIN*CNT_W-1:0] vres;
  } timing_t;

  // Sync flags hold "active", not pin level; polarity is applied at the outputs.
  typedef struct packed {
    logic             de;
    logic             hs;
    logic             vs;
    logic             fs;
    logic [N_WIN-1:0] rden;
`ifdef VTG_COORD_EN
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
`endif
  } dec_t;

  vtg_state_e       state, state_nxt;
  logic [CNT_W-1:0] h_cnt, v_cnt, h_nxt, v_nxt;
  logic [CNT_W-1:0] h_last, v_last;
  logic             h_at_end, v_at_end;
  logic             pend, load, upd_ack;
  timing_t          live, shd;
  logic             run;

  assign live = '{h_total: I_h_total, h_sync: I_h_sync, h_bporch: I_h_bporch,
                  h_res: I_h_res, v_total: I_v_total, v_sync: I_v_sync,
                  v_bporch: I_v_bporch, v_res: I_v_res, hoff: I_win_hoff,
                  voff: I_win_voff, hres: I_win_hres, vres: I_win_vres};

  // A total of 0 behaves like 1, so the counters can never run away.
  assign h_last   = (shd.h_total == '0) ? '0 : shd.h_total - ONE;
  assign v_last   = (shd.v_total == '0) ? '0 : shd.v_total - ONE;
  assign h_at_end = (h_cnt == h_last);
  assign v_at_end = (v_cnt == v_last);
  assign run      = (state == VTG_RUN);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    h_nxt     = h_cnt;
    v_nxt     = v_cnt;
    load      = 1'b0;
    unique case (state)
      VTG_IDLE: begin
        h_nxt = '0;
        v_nxt = '0;
        if (I_en) begin
          state_nxt = VTG_RUN;
          load      = 1'b1;
        end
      end
      VTG_RUN: begin
        if (h_at_end) begin
          h_nxt = '0;
          if (v_at_end) begin
            v_nxt = '0;
            load  = pend | I_cfg_upd;
            if (!I_en) state_nxt = VTG_IDLE;
          end else begin
            v_nxt = v_cnt + ONE;
          end
        end else begin
          h_nxt = h_cnt + ONE;
        end
      end
      default: state_nxt = VTG_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= VTG_IDLE;
      h_cnt   <= '0;
      v_cnt   <= '0;
      shd     <= '0;
      pend    <= 1'b0;
      upd_ack <= 1'b0;
    end else begin
      state   <= state_nxt;
      h_cnt   <= h_nxt;
      v_cnt   <= v_nxt;
      if (load) shd <= live;
      pend    <= load ? 1'b0 : (pend | I_cfg_upd);
      upd_ack <= load;
    end
  end

  // DE bounds need two extra bits: sync + porch + res may exceed CNT_W+1 bits.
  logic [CNT_W:0]   ha0, va0;
  logic [CNT_W+1:0] ha1, va1;
  logic             de_h, de_v, de;
  logic [CNT_W-1:0] rel_x, rel_y;
  logic [N_WIN-1:0] rden;

  assign ha0   = {1'b0, shd.h_sync} + {1'b0, shd.h_bporch};
  assign va0   = {1'b0, shd.v_sync} + {1'b0, shd.v_bporch};
  assign ha1   = {1'b0, ha0} + {2'b00, shd.h_res};
  assign va1   = {1'b0, va0} + {2'b00, shd.v_res};
  assign de_h  = ({1'b0, h_cnt} >= ha0) && ({2'b00, h_cnt} < ha1);
  assign de_v  = ({1'b0, v_cnt} >= va0) && ({2'b00, v_cnt} < va1);
  assign de    = run && de_h && de_v;
  assign rel_x = h_cnt - ha0[CNT_W-1:0];
  assign rel_y = v_cnt - va0[CNT_W-1:0];

  for (genvar k = 0; k < N_WIN; k++) begin : g_win
    vtg_win_dec #(.CNT_W(CNT_W)) u_win_dec (
      .de    (de),
      .rel_x (rel_x),
      .rel_y (rel_y),
      .hoff  (shd.hoff[k*CNT_W +: CNT_W]),
      .voff  (shd.voff[k*CNT_W +: CNT_W]),
      .hres  (shd.hres[k*CNT_W +: CNT_W]),
      .vres  (shd.vres[k*CNT_W +: CNT_W]),
      .rden  (rden[k])
    );
  end

  dec_t dec;
  dec_t pipe [DLY];

  always_comb begin
    dec      = '0;
    dec.de   = de;
    dec.hs   = run && (h_cnt < shd.h_sync);
    dec.vs   = run && (v_cnt < shd.v_sync);
    dec.fs   = run && (h_cnt == '0) && (v_cnt == '0);
    dec.rden = rden;
`ifdef VTG_COORD_EN
    dec.x    = de ? rel_x : '0;
    dec.y    = de ? rel_y : '0;
`endif
  end

  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      // NOTE: the delay line is reset because the outputs must show idle levels during reset.
      for (int i = 0; i < DLY; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= dec;
      for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign O_de      = pipe[DLY-1].de;
  assign O_hs      = pipe[DLY-1].hs ? HS_POL : ~HS_POL;
  assign O_vs      = pipe[DLY-1].vs ? VS_POL : ~VS_POL;
  assign O_rden    = pipe[DLY-1].rden;
  assign O_fs      = pipe[DLY-1].fs;
  assign O_upd_ack = upd_ack;
  assign O_busy    = run;
`ifdef VTG_COORD_EN
  assign O_x       = pipe[DLY-1].x;
  assign O_y       = pipe[DLY-1].y;
`endif

endmodule

// File: tb/tb_vid_timing_gen.sv
// Self-checking bench for vid_timing_gen: a behavioural frame model feeds a
// scoreboard queue of expected outputs, plus per-scenario count checks.
module tb_vid_timing_gen;

  localparam int CNT_W  = 16;
  localparam int N_WIN  = 2;
  localparam int DLY    = 2;
  localparam bit HS_POL = 1'b0;
  localparam bit VS_POL = 1'b0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, cfg_upd;
  logic [CNT_W-1:0] h_total, h_sync, h_bporch, h_res;
  logic [CNT_W-1:0] v_total, v_sync, v_bporch, v_res;
  logic [N_WIN*CNT_W-1:0] win_hoff, win_voff, win_hres, win_vres;
  logic de, hs, vs, fs, upd_ack, busy;
  logic [N_WIN-1:0] rden;
`ifdef VTG_COORD_EN
  logic [CNT_W-1:0] x, y;
`endif

  vid_timing_gen #(
    .CNT_W(CNT_W), .N_WIN(N_WIN), .DLY(DLY), .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) dut (
    .I_pxl_clk (clk),      .I_rst_n   (rst_n),    .I_en       (en),
    .I_cfg_upd (cfg_upd),  .I_h_total (h_total),  .I_h_sync   (h_sync),
    .I_h_bporch(h_bporch), .I_h_res   (h_res),    .I_v_total  (v_total),
    .I_v_sync  (v_sync),   .I_v_bporch(v_bporch), .I_v_res    (v_res),
    .I_win_hoff(win_hoff), .I_win_voff(win_voff), .I_win_hres (win_hres),
    .I_win_vres(win_vres), .O_de      (de),       .O_hs       (hs),
    .O_vs      (vs),       .O_rden    (rden),     .O_fs       (fs),
    .O_upd_ack (upd_ack),  .O_busy    (busy)
`ifdef VTG_COORD_EN
    , .O_x(x), .O_y(y)
`endif
  );

  typedef struct packed {
    logic             de;
    logic             hs;
    logic             vs;
    logic             fs;
    logic [N_WIN-1:0] rden;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
  } obs_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  obs_t exp_q[$];

  // Reference model of the generator, in plain integers.
  bit m_run, m_pend, m_ack;
  int m_h, m_v;
  int sh_ht, sh_hs, sh_hbp, sh_hr, sh_vt, sh_vs, sh_vbp, sh_vr;
  int sh_hoff[N_WIN], sh_voff[N_WIN], sh_hres[N_WIN], sh_vres[N_WIN];

  function automatic obs_t exp_decode();
    obs_t e;
    int   ha0, va0, rx, ry;
    bit   d;
    e    = '0;
    e.hs = ~HS_POL;
    e.vs = ~VS_POL;
    if (m_run) begin
      ha0 = sh_hs + sh_hbp;
      va0 = sh_vs + sh_vbp;
      d   = (m_h >= ha0) && (m_h < ha0 + sh_hr) && (m_v >= va0) && (m_v < va0 + sh_vr);
      rx  = m_h - ha0;
      ry  = m_v - va0;
      e.de = d;
      if (m_h < sh_hs) e.hs = HS_POL;
      if (m_v < sh_vs) e.vs = VS_POL;
      e.fs = (m_h == 0) && (m_v == 0);
      for (int k = 0; k < N_WIN; k++)
        e.rden[k] = d && (rx >= sh_hoff[k]) && (rx < sh_hoff[k] + sh_hres[k]) &&
                    (ry >= sh_voff[k]) && (ry < sh_voff[k] + sh_vres[k]);
`ifdef VTG_COORD_EN
      if (d) begin
        e.x = CNT_W'(rx);
        e.y = CNT_W'(ry);
      end
`endif
    end
    return e;
  endfunction

  task automatic load_shadows();
    sh_ht = int'(h_total); sh_hs = int'(h_sync); sh_hbp = int'(h_bporch); sh_hr = int'(h_res);
    sh_vt = int'(v_total); sh_vs = int'(v_sync); sh_vbp = int'(v_bporch); sh_vr = int'(v_res);
    for (int k = 0; k < N_WIN; k++) begin
      sh_hoff[k] = int'(win_hoff[k*CNT_W +: CNT_W]);
      sh_voff[k] = int'(win_voff[k*CNT_W +: CNT_W]);
      sh_hres[k] = int'(win_hres[k*CNT_W +: CNT_W]);
      sh_vres[k] = int'(win_vres[k*CNT_W +: CNT_W]);
    end
  endtask

  task automatic step_model();
    bit ld;
    int ht, vt;
    ld = 1'b0;
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        ld    = 1'b1;
      end
      m_h = 0;
      m_v = 0;
    end else begin
      ht = (sh_ht == 0) ? 1 : sh_ht;
      vt = (sh_vt == 0) ? 1 : sh_vt;
      if (m_h == ht - 1) begin
        m_h = 0;
        if (m_v == vt - 1) begin
          m_v = 0;
          if (m_pend || cfg_upd) ld = 1'b1;
          if (!en) m_run = 1'b0;
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
    m_pend = ld ? 1'b0 : (m_pend || cfg_upd);
    m_ack  = ld;
    if (ld) load_shadows();
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pend = 1'b0; m_ack = 1'b0; m_h = 0; m_v = 0;
    sh_ht = 0; sh_hs = 0; sh_hbp = 0; sh_hr = 0; sh_vt = 0; sh_vs = 0; sh_vbp = 0; sh_vr = 0;
    for (int k = 0; k < N_WIN; k++) begin
      sh_hoff[k] = 0; sh_voff[k] = 0; sh_hres[k] = 0; sh_vres[k] = 0;
    end
    exp_q.delete();
    for (int i = 0; i < DLY - 1; i++) exp_q.push_back(exp_decode());
  endtask

  // One clock: push this cycle's expected decode, advance, pop the entry now due.
  task automatic tick();
    obs_t e, g;
    exp_q.push_back(exp_decode());
    step_model();
    @(posedge clk);
    #1;
    e      = exp_q.pop_front();
    g      = '0;
    g.de   = de; g.hs = hs; g.vs = vs; g.fs = fs; g.rden = rden;
`ifdef VTG_COORD_EN
    g.x    = x;  g.y  = y;
`endif
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL scoreboard cyc=%0d got de=%b hs=%b vs=%b fs=%b rden=%b x=%0d y=%0d exp de=%b hs=%b vs=%b fs=%b rden=%b x=%0d y=%0d",
               cyc, g.de, g.hs, g.vs, g.fs, g.rden, g.x, g.y, e.de, e.hs, e.vs, e.fs, e.rden, e.x, e.y);
    end
    checks++;
    if ({busy, upd_ack} !== {m_run, m_ack}) begin
      errors++;
      $display("FAIL busy_ack cyc=%0d got busy=%b ack=%b exp busy=%b ack=%b", cyc, busy, upd_ack, m_run, m_ack);
    end
    cyc++;
  endtask

  task automatic set_win(input int k, input int ho, input int vo, input int hr, input int vr);
    win_hoff[k*CNT_W +: CNT_W] = CNT_W'(ho);
    win_voff[k*CNT_W +: CNT_W] = CNT_W'(vo);
    win_hres[k*CNT_W +: CNT_W] = CNT_W'(hr);
    win_vres[k*CNT_W +: CNT_W] = CNT_W'(vr);
  endtask

  task automatic set_base_cfg();
    h_total = 10; h_sync = 2; h_bporch = 2; h_res = 4;
    v_total = 6;  v_sync = 1; v_bporch = 1; v_res = 3;
    set_win(0, 1, 0, 2, 1);
    set_win(1, 3, 0, 5, 3);
  endtask

  task automatic run_to_frame_start(output bit ok);
    int n;
    n = 0;
    while (!(m_run && m_h == 0 && m_v == 0) && n < 200) begin
      tick();
      n++;
    end
    ok = m_run && (m_h == 0) && (m_v == 0);
  endtask

  task automatic test_reset();
    en = 1'b0; cfg_upd = 1'b0; rst_n = 1'b0;
    h_total = '0; h_sync = '0; h_bporch = '0; h_res = '0;
    v_total = '0; v_sync = '0; v_bporch = '0; v_res = '0;
    win_hoff = '0; win_voff = '0; win_hres = '0; win_vres = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (de !== 1'b0)      begin errors++; $display("FAIL rst_de got=%b exp=0", de); end
    checks++; if (hs !== ~HS_POL)   begin errors++; $display("FAIL rst_hs got=%b exp=%b", hs, ~HS_POL); end
    checks++; if (vs !== ~VS_POL)   begin errors++; $display("FAIL rst_vs got=%b exp=%b", vs, ~VS_POL); end
    checks++; if (rden !== '0)      begin errors++; $display("FAIL rst_rden got=%b exp=0", rden); end
    checks++; if (fs !== 1'b0)      begin errors++; $display("FAIL rst_fs got=%b exp=0", fs); end
    checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", upd_ack); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    model_reset();
    repeat (5) tick();
  endtask

  task automatic test_base_timing();
    int first_fs, fs_n, de_n, hs_n, vs_n, r0_n, r1_n;
    int sx, sy;
    first_fs = -1; fs_n = 0; de_n = 0; hs_n = 0; vs_n = 0; r0_n = 0; r1_n = 0;
    sx = 0; sy = 0;
    set_base_cfg();
    en = 1'b1;
    for (int i = 0; i < DLY + 120; i++) begin
      tick();
      if (i == 0) begin
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL base_busy_rise got=%b exp=1", busy); end
        checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL base_start_ack got=%b exp=1", upd_ack); end
      end
      if (fs === 1'b1 && first_fs < 0) first_fs = i;
      if (i >= DLY) begin
        fs_n += int'(fs === 1'b1);
        de_n += int'(de === 1'b1);
        hs_n += int'(hs === HS_POL);
        vs_n += int'(vs === VS_POL);
        r0_n += int'(rden[0] === 1'b1);
        r1_n += int'(rden[1] === 1'b1);
`ifdef VTG_COORD_EN
        if (de === 1'b1) begin
          sx += int'(x);
          sy += int'(y);
        end
`endif
      end
    end
    checks++; if (first_fs != DLY) begin errors++; $display("FAIL base_fs_latency got=%0d exp=%0d", first_fs, DLY); end
    checks++; if (fs_n != 2)  begin errors++; $display("FAIL base_fs_count got=%0d exp=2", fs_n); end
    checks++; if (de_n != 24) begin errors++; $display("FAIL base_de_count got=%0d exp=24", de_n); end
    checks++; if (hs_n != 24) begin errors++; $display("FAIL base_hs_count got=%0d exp=24", hs_n); end
    checks++; if (vs_n != 20) begin errors++; $display("FAIL base_vs_count got=%0d exp=20", vs_n); end
    checks++; if (r0_n != 4)  begin errors++; $display("FAIL win0_count got=%0d exp=4", r0_n); end
    checks++; if (r1_n != 6)  begin errors++; $display("FAIL win1_clip_count got=%0d exp=6", r1_n); end
`ifdef VTG_COORD_EN
    checks++; if (sx != 36) begin errors++; $display("FAIL coord_x_sum got=%0d exp=36", sx); end
    checks++; if (sy != 24) begin errors++; $display("FAIL coord_y_sum got=%0d exp=24", sy); end
`endif
  endtask

  task automatic test_win_disable();
    bit ok;
    int r0_n, r1_n;
    r0_n = 0; r1_n = 0;
    set_win(1, 3, 0, 0, 3);
    cfg_upd = 1'b1;
    tick();
    cfg_upd = 1'b0;
    run_to_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL win_dis_frame_wait got=timeout exp=frame_start"); end
    checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL win_dis_ack got=%b exp=1", upd_ack); end
    for (int i = 0; i < DLY + 60; i++) begin
      tick();
      if (i >= DLY) begin
        r0_n += int'(rden[0] === 1'b1);
        r1_n += int'(rden[1] === 1'b1);
      end
    end
    checks++; if (r0_n != 2) begin errors++; $display("FAIL win_dis_r0 got=%0d exp=2", r0_n); end
    checks++; if (r1_n != 0) begin errors++; $display("FAIL win_dis_r1 got=%0d exp=0", r1_n); end
  endtask

  task automatic test_update();
    bit ok;
    int de_a, de_b, r0_b, ack_n, ack_at;
    de_a = 0; de_b = 0; r0_b = 0; ack_n = 0; ack_at = -1;
    run_to_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL upd_frame_wait got=timeout exp=frame_start"); end
    for (int i = 0; i < DLY + 120; i++) begin
      if (i == 10) begin h_res = 3; cfg_upd = 1'b1; end
      if (i == 11) cfg_upd = 1'b0;
      if (i == 30) h_res = 2;
      if (i == 40) cfg_upd = 1'b1;
      if (i == 41) cfg_upd = 1'b0;
      tick();
      if (upd_ack === 1'b1) begin ack_n++; ack_at = i; end
      if (i >= DLY && i < DLY + 60) de_a += int'(de === 1'b1);
      if (i >= DLY + 60) begin
        de_b += int'(de === 1'b1);
        r0_b += int'(rden[0] === 1'b1);
      end
    end
    checks++; if (de_a != 12) begin errors++; $display("FAIL upd_old_frame_de got=%0d exp=12", de_a); end
    checks++; if (de_b != 6)  begin errors++; $display("FAIL upd_new_frame_de got=%0d exp=6", de_b); end
    checks++; if (r0_b != 1)  begin errors++; $display("FAIL upd_new_frame_r0 got=%0d exp=1", r0_b); end
    checks++; if (ack_n != 1) begin errors++; $display("FAIL upd_ack_count got=%0d exp=1", ack_n); end
    checks++; if (ack_at != 59) begin errors++; $display("FAIL upd_ack_cycle got=%0d exp=59", ack_at); end
  endtask

  task automatic test_back_to_back();
    int n, de_n, r1_n;
    n = 0; de_n = 0; r1_n = 0;
    while (!(m_run && m_h == 9 && m_v == 5) && n < 100) begin
      tick();
      n++;
    end
    checks++; if (!(m_h == 9 && m_v == 5)) begin errors++; $display("FAIL b2b_wait got=timeout exp=last_pixel"); end
    h_res = 4;
    set_win(1, 3, 0, 5, 3);
    cfg_upd = 1'b1;
    tick();
    cfg_upd = 1'b0;
    checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack got=%b exp=1", upd_ack); end
    for (int i = 0; i < DLY + 60; i++) begin
      tick();
      if (i >= DLY) begin
        de_n += int'(de === 1'b1);
        r1_n += int'(rden[1] === 1'b1);
      end
    end
    checks++; if (de_n != 12) begin errors++; $display("FAIL b2b_de got=%0d exp=12", de_n); end
    checks++; if (r1_n != 3)  begin errors++; $display("FAIL b2b_r1 got=%0d exp=3", r1_n); end
  endtask

  task automatic test_stop();
    bit ok;
    int n, busy_n;
    run_to_frame_start(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop_frame_wait got=timeout exp=frame_start"); end
    repeat (23) tick();
    en = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++; if (n != 37) begin errors++; $display("FAIL stop_busy_fall got=%0d exp=37", n); end
    repeat (DLY) tick();
    checks++;
    if ({de, hs, vs, fs, rden} !== {1'b0, ~HS_POL, ~VS_POL, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL stop_idle_outputs got=%b%b%b%b%b exp=0110_00", de, hs, vs, fs, rden);
    end
    busy_n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      busy_n += int'(busy !== 1'b0);
    end
    checks++; if (busy_n != 0) begin errors++; $display("FAIL stop_stays_idle got=%0d exp=0", busy_n); end
  endtask

  task automatic test_reset_midline();
    int n, first_fs;
    en = 1'b1;
    n = 0;
    while (de !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    tick();
    checks++; if (de !== 1'b1) begin errors++; $display("FAIL mid_precond_de got=%b exp=1", de); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (de !== 1'b0)      begin errors++; $display("FAIL mid_rst_de got=%b exp=0", de); end
    checks++; if (hs !== ~HS_POL)   begin errors++; $display("FAIL mid_rst_hs got=%b exp=%b", hs, ~HS_POL); end
    checks++; if (vs !== ~VS_POL)   begin errors++; $display("FAIL mid_rst_vs got=%b exp=%b", vs, ~VS_POL); end
    checks++; if (rden !== '0)      begin errors++; $display("FAIL mid_rst_rden got=%b exp=0", rden); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
`ifdef VTG_COORD_EN
    checks++; if ({x, y} !== '0)    begin errors++; $display("FAIL mid_rst_xy got=%0d/%0d exp=0/0", x, y); end
`endif
    en = 1'b0;
    #2 rst_n = 1'b1;
    model_reset();
    repeat (5) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_wait_idle got=%b exp=0", busy); end
    en = 1'b1;
    first_fs = -1;
    for (int i = 0; i < DLY + 4; i++) begin
      tick();
      if (fs === 1'b1 && first_fs < 0) first_fs = i;
    end
    checks++; if (first_fs != DLY) begin errors++; $display("FAIL mid_restart_fs got=%0d exp=%0d", first_fs, DLY); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_base_timing();
    test_win_disable();
    test_update();
    test_back_to_back();
    test_stop();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
